// File: rtl/mmio_bridge.sv
// mmio_bridge: memory-mapped I/O bridge between the datapath memory port and
// block RAM port A.
//   - Addresses below IO_BASE pass straight through to the RAM.
//   - IO_BASE+0 LED (rw), +1 SW (ro, 2-flop synchronized),
//     +2 TIMER (rw, prescaled up-counter), +3 TX FIFO push / status read.
//   - Read data is registered one cycle, which matches the RAM's registered read.
// Ports:
//   clk, rst (sync, active-low)
//   cpu_addr/cpu_wdata/cpu_we in, cpu_rdata out      datapath side
//   mem_addr/mem_wdata/mem_we out, mem_q in           RAM port A side
//   sw in, led out                                    board I/O
//   tx_data/tx_valid out, tx_ready in                 FIFO consumer side
module mmio_bridge #(
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMER_DIV  = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [15:0] cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_q,
    input  logic [9:0]  sw,
    output logic [9:0]  led,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(TIMER_DIV - 1);

    logic [9:0]       led_q, led_d;
    logic [9:0]       sw_meta_q, sw_sync_q;
    logic [15:0]      timer_q, timer_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             sel_io_q;
    logic [15:0]      io_rd_q, io_rd_d;
    logic [15:0]      fifo_q [FIFO_DEPTH];

    logic        is_io;
    logic [15:0] off;
    logic        sel_led, sel_timer, sel_tx;
    logic        empty, full, pop, push_req, push_ok, status_rd, tc;

    assign is_io     = cpu_addr >= IO_BASE;
    assign off       = cpu_addr - IO_BASE;
    assign sel_led   = is_io && (off == 16'd0);
    assign sel_timer = is_io && (off == 16'd2);
    assign sel_tx    = is_io && (off == 16'd3);

    assign mem_addr  = cpu_addr;
    assign mem_wdata = cpu_wdata;
    assign mem_we    = cpu_we && !is_io;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign pop       = !empty && tx_ready;
    assign push_req  = cpu_we && sel_tx;
    // A pop frees the slot the push lands in, so a full FIFO still accepts.
    assign push_ok   = push_req && (!full || pop) && rst;
    assign status_rd = sel_tx && !cpu_we;
    assign tc        = (pre_q == PRE_TC);

    assign led       = led_q;
    assign tx_valid  = !empty;
    assign tx_data   = empty ? 16'h0000 : fifo_q[rd_ptr_q];
    assign cpu_rdata = sel_io_q ? io_rd_q : mem_q;

    always_comb begin
        led_d    = led_q;
        timer_d  = timer_q;
        pre_d    = pre_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        io_rd_d  = 16'h0000;

        if (cpu_we && sel_led) begin
            led_d = cpu_wdata[9:0];
        end

        // A software write beats a coincident prescaler terminal count.
        if (cpu_we && sel_timer) begin
            timer_d = cpu_wdata;
            pre_d   = '0;
        end else if (tc) begin
            timer_d = timer_q + 16'd1;
            pre_d   = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (status_rd) begin
            ovf_d = 1'b0;
        end

        if (is_io) begin
            case (off)
                16'd0:   io_rd_d = {6'b0, led_q};
                16'd1:   io_rd_d = {6'b0, sw_sync_q};
                16'd2:   io_rd_d = timer_q;
                16'd3:   io_rd_d = {13'b0, ovf_q, full, empty};
                default: io_rd_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            timer_q   <= '0;
            pre_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            // Parked on an unmapped I/O offset so cpu_rdata reads 0.
            sel_io_q  <= 1'b1;
            io_rd_q   <= 16'h0000;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            timer_q   <= timer_d;
            pre_q     <= pre_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            sel_io_q  <= is_io;
            io_rd_q   <= io_rd_d;
        end
    end

    // Storage needs no reset: tx_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;
    localparam int          TDIV  = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] IOB   = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_rdata, mem_addr, mem_wdata, mem_q;
    logic        mem_we;
    logic [9:0]  sw = 10'h0, led;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    mmio_bridge #(.IO_BASE(IOB), .FIFO_DEPTH(DEPTH), .TIMER_DIV(TDIV)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
        .sw(sw), .led(led),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Block RAM stand-in: registered, read-before-write.
    logic [15:0] bram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) bram[i] = 16'h0;
        mem_q = 16'h0;
    end
    always @(posedge clk) begin
        mem_q <= bram[mem_addr];
        if (mem_we) bram[mem_addr] <= mem_wdata;
    end

    // Reference model state.
    int          cyc = 0;
    int          nvec = 0, nerr = 0;
    logic [15:0] ram_m [logic [15:0]];
    logic [9:0]  led_m = 10'h0;
    logic [9:0]  s1 = 10'h0, s2 = 10'h0;
    int          tw = 0;
    logic [15:0] tv = 16'h0;
    logic [15:0] q [$];
    bit          ovf_m = 1'b0;
    logic [15:0] exp_rd = 16'h0;

    // Timer value seen at edge e, before that edge's update, counting whole
    // prescaler periods elapsed since the last load at edge tw.
    function automatic logic [15:0] timer_at(int e);
        int k;
        k = (e - tw - 1) / TDIV;
        return tv + 16'(k);
    endfunction

    // Advance one clock: apply the reference rules to the inputs as they stand,
    // then clock the DUT. exp_rd is what cpu_rdata must show afterwards.
    task automatic step();
        int          e;
        bit          io, acc, pop, wr_tx;
        logic [15:0] off, rd;
        e   = cyc + 1;
        io  = (cpu_addr >= IOB);
        off = cpu_addr - IOB;
        rd  = 16'h0;
        if (!rst) begin
            led_m = 10'h0; s1 = 10'h0; s2 = 10'h0;
            tw = e; tv = 16'h0;
            q.delete(); ovf_m = 1'b0;
        end else begin
            if (!io) rd = ram_m.exists(cpu_addr) ? ram_m[cpu_addr] : 16'h0;
            else begin
                case (off)
                    16'd0:   rd = {6'b0, led_m};
                    16'd1:   rd = {6'b0, s2};
                    16'd2:   rd = timer_at(e);
                    16'd3:   rd = {13'b0, ovf_m, (q.size() == DEPTH), (q.size() == 0)};
                    default: rd = 16'h0;
                endcase
            end
            pop   = (q.size() > 0) && tx_ready;
            wr_tx = cpu_we && io && (off == 16'd3);
            acc   = wr_tx && ((q.size() < DEPTH) || pop);
            if (wr_tx && !acc) ovf_m = 1'b1;
            else if (io && (off == 16'd3) && !cpu_we) ovf_m = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(cpu_wdata);
            if (cpu_we && io && off == 16'd0) led_m = cpu_wdata[9:0];
            if (cpu_we && io && off == 16'd2) begin tw = e; tv = cpu_wdata; end
            s2 = s1; s1 = sw;
        end
        if (cpu_we && !io) ram_m[cpu_addr] = cpu_wdata;
        @(posedge clk);
        #1;
        cyc++;
        exp_rd = rd;
    endtask

    task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic we);
        cpu_addr = a; cpu_wdata = d; cpu_we = we;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus(16'h0020, 16'hBEEF, 1'b1);
        #1;
        nvec++;
        if (mem_we !== 1'b1) begin nerr++; $display("FAIL reset_mem_we got=%b exp=1", mem_we); end
        step();
        bus(16'h0, 16'h0, 1'b0);
        step();
        nvec++;
        if (led !== 10'h0) begin nerr++; $display("FAIL reset_led got=%h exp=000", led); end
        nvec++;
        if (tx_valid !== 1'b0 || tx_data !== 16'h0) begin
            nerr++; $display("FAIL reset_tx valid=%b data=%h exp valid=0 data=0000", tx_valid, tx_data);
        end
        nvec++;
        if (cpu_rdata !== 16'h0) begin nerr++; $display("FAIL reset_rdata got=%h exp=0000", cpu_rdata); end
        rst = 1'b1;
    endtask

    task automatic test_ram();
        bus(16'h0010, 16'h1234, 1'b1);
        #1;
        nvec++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
            nerr++; $display("FAIL ram_port we=%b addr=%h data=%h exp 1/0010/1234", mem_we, mem_addr, mem_wdata);
        end
        step();
        bus(16'h0010, 16'h0, 1'b0);
        #1;
        nvec++;
        if (mem_we !== 1'b0) begin nerr++; $display("FAIL ram_we_load got=%b exp=0", mem_we); end
        step();
        nvec++;
        if (cpu_rdata !== 16'h1234 || exp_rd !== 16'h1234) begin
            nerr++; $display("FAIL ram_rd_1234 got=%h exp=1234", cpu_rdata);
        end
        for (int i = 0; i < 40; i++) begin
            bus(16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
            step();
            nvec++;
            if (cpu_rdata !== exp_rd) begin nerr++; $display("FAIL ram_rand it=%0d got=%h exp=%h", i, cpu_rdata, exp_rd); end
        end
    endtask

    task automatic test_led_sw();
        logic [15:0] v;
        bus(IOB, 16'h03FF, 1'b1);
        #1;
        nvec++;
        if (mem_we !== 1'b0) begin nerr++; $display("FAIL led_mem_we got=%b exp=0", mem_we); end
        step();
        nvec++;
        if (led !== 10'h3FF) begin nerr++; $display("FAIL led_3ff got=%h exp=3ff", led); end
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            bus(IOB, v, 1'b1); step();
            bus(IOB, 16'h0, 1'b0); step();
            nvec++;
            if (led !== v[9:0] || cpu_rdata !== exp_rd) begin
                nerr++; $display("FAIL led_rw led=%h rd=%h exp led=%h rd=%h", led, cpu_rdata, v[9:0], exp_rd);
            end
        end
        sw = 10'h155;
        bus(16'h0, 16'h0, 1'b0); step(); step();
        bus(IOB + 16'd1, 16'h0, 1'b0); step();
        nvec++;
        if (cpu_rdata !== 16'h0155 || exp_rd !== 16'h0155) begin
            nerr++; $display("FAIL sw_155 got=%h exp=0155", cpu_rdata);
        end
        for (int i = 0; i < 12; i++) begin
            sw = 10'($urandom);
            step();
            nvec++;
            if (cpu_rdata !== exp_rd) begin nerr++; $display("FAIL sw_sync it=%0d got=%h exp=%h", i, cpu_rdata, exp_rd); end
        end
        bus(IOB + 16'd1, 16'($urandom), 1'b1); step();
        nvec++;
        if (led !== led_m) begin nerr++; $display("FAIL sw_write_ignored led=%h exp=%h", led, led_m); end
        for (int i = 0; i < 10; i++) begin
            bus(IOB + 16'($urandom_range(4, 255)), 16'($urandom), 1'($urandom_range(0, 1)));
            step();
            nvec++;
            if (cpu_rdata !== 16'h0 || led !== led_m) begin
                nerr++; $display("FAIL unmapped addr=%h rd=%h led=%h exp rd=0000 led=%h", cpu_addr, cpu_rdata, led, led_m);
            end
        end
    endtask

    task automatic test_timer();
        logic [15:0] v;
        int          n;
        bus(IOB + 16'd2, 16'hFFFE, 1'b1); step();
        bus(16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) step();
        bus(IOB + 16'd2, 16'h0, 1'b0); step();
        nvec++;
        if (cpu_rdata !== 16'h0000 || exp_rd !== 16'h0000) begin
            nerr++; $display("FAIL timer_wrap got=%h exp=0000", cpu_rdata);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            nvec++;
            if (cpu_rdata !== exp_rd) begin nerr++; $display("FAIL timer_run it=%0d got=%h exp=%h", i, cpu_rdata, exp_rd); end
        end
        for (int r = 0; r < 3; r++) begin
            bus(16'h0, 16'h0, 1'b0);
            n = 0;
            while (((cyc + 1 - tw) % TDIV) != 0 && n < 2 * TDIV) begin step(); n++; end
            v = 16'($urandom);
            bus(IOB + 16'd2, v, 1'b1); step();
            bus(IOB + 16'd2, 16'h0, 1'b0); step();
            nvec++;
            if (cpu_rdata !== v || exp_rd !== v) begin
                nerr++; $display("FAIL timer_write_at_tc got=%h exp=%h", cpu_rdata, v);
            end
        end
    endtask

    task automatic test_fifo_fill();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus(IOB + 16'd3, 16'($urandom), 1'b1); step();
            nvec++;
            if (tx_valid !== 1'b1 || tx_data !== q[0]) begin
                nerr++; $display("FAIL fill_head it=%0d valid=%b data=%h exp valid=1 data=%h", i, tx_valid, tx_data, q[0]);
            end
        end
        bus(IOB + 16'd3, 16'h0, 1'b0); step();
        nvec++;
        if (cpu_rdata !== 16'h0006 || exp_rd !== 16'h0006) begin
            nerr++; $display("FAIL status_full_ovf got=%h exp=0006", cpu_rdata);
        end
        step();
        nvec++;
        if (cpu_rdata !== 16'h0002 || exp_rd !== 16'h0002) begin
            nerr++; $display("FAIL status_ovf_cleared got=%h exp=0002", cpu_rdata);
        end
    endtask

    task automatic test_drain();
        int n;
        bus(16'h0, 16'h0, 1'b0);
        tx_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 2 * DEPTH) begin
            nvec++;
            if (tx_valid !== 1'b1 || tx_data !== q[0]) begin
                nerr++; $display("FAIL drain_seq n=%0d valid=%b data=%h exp valid=1 data=%h", n, tx_valid, tx_data, q[0]);
            end
            step(); n++;
        end
        nvec++;
        if (tx_valid !== 1'b0 || n != DEPTH) begin
            nerr++; $display("FAIL drain_empty valid=%b pops=%0d exp valid=0 pops=%0d", tx_valid, n, DEPTH);
        end
        tx_ready = 1'b0;
        bus(IOB + 16'd3, 16'h0, 1'b0); step();
        nvec++;
        if (cpu_rdata !== 16'h0001 || exp_rd !== 16'h0001) begin
            nerr++; $display("FAIL status_empty got=%h exp=0001", cpu_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] f, last;
        int          n;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin bus(IOB + 16'd3, 16'($urandom), 1'b1); step(); end
        f = 16'($urandom);
        tx_ready = 1'b1;
        bus(IOB + 16'd3, f, 1'b1); step();
        tx_ready = 1'b0;
        bus(IOB + 16'd3, 16'h0, 1'b0); step();
        nvec++;
        if (cpu_rdata !== 16'h0002 || exp_rd !== 16'h0002) begin
            nerr++; $display("FAIL push_pop_full status=%h exp=0002", cpu_rdata);
        end
        bus(16'h0, 16'h0, 1'b0);
        tx_ready = 1'b1;
        n = 0; last = 16'h0;
        while (q.size() > 0 && n < 2 * DEPTH) begin
            nvec++;
            if (tx_data !== q[0]) begin nerr++; $display("FAIL b2b_seq n=%0d got=%h exp=%h", n, tx_data, q[0]); end
            last = tx_data;
            step(); n++;
        end
        nvec++;
        if (last !== f || n != DEPTH) begin
            nerr++; $display("FAIL b2b_last got=%h pops=%0d exp=%h pops=%0d", last, n, f, DEPTH);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 300; i++) begin
            tx_ready = 1'($urandom_range(0, 2) == 0);
            op = $urandom_range(0, 9);
            if (op < 5)      bus(IOB + 16'd3, 16'($urandom), 1'b1);
            else if (op < 7) bus(IOB + 16'd3, 16'h0, 1'b0);
            else if (op < 8) bus(IOB + 16'($urandom_range(0, 2)), 16'h0, 1'b0);
            else             bus(16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
            step();
            nvec++;
            if (cpu_rdata !== exp_rd || tx_valid !== (q.size() != 0) || (q.size() != 0 && tx_data !== q[0])) begin
                nerr++;
                $display("FAIL rand_mix it=%0d rd=%h exp=%h valid=%b exp_valid=%b data=%h exp_data=%h",
                         i, cpu_rdata, exp_rd, tx_valid, (q.size() != 0), tx_data, (q.size() != 0) ? q[0] : 16'h0);
            end
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus(IOB, 16'h02A5, 1'b1); step();
        for (int i = 0; i < 3; i++) begin bus(IOB + 16'd3, 16'($urandom), 1'b1); step(); end
        bus(IOB + 16'd2, 16'h0, 1'b0);
        tx_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        nvec++;
        if (tx_valid !== 1'b0 || led !== 10'h0 || cpu_rdata !== 16'h0) begin
            nerr++; $display("FAIL reset_mid valid=%b led=%h rd=%h exp 0/000/0000", tx_valid, led, cpu_rdata);
        end
        rst = 1'b1;
        step(); step();
        nvec++;
        if (tx_valid !== 1'b0 || cpu_rdata !== exp_rd) begin
            nerr++; $display("FAIL after_reset valid=%b timer=%h exp valid=0 timer=%h", tx_valid, cpu_rdata, exp_rd);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led_sw();
        test_timer();
        test_fifo_fill();
        test_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
